// File: rtl/instr_mem_arbiter_pkg.sv
// Shared types and address helpers for the instruction-memory arbiter.
package instr_mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {RUN, HOLD, LOAD, REFILL} arb_state_t;

   // A byte address is usable only when word aligned and inside the array.
   function automatic logic addr_valid(input logic [31:0] addr, input int unsigned mem_words);
      return (addr[1:0] == 2'b00) && (addr < 32'(WORD_BYTES * mem_words));
   endfunction

   function automatic logic [29:0] word_index(input logic [31:0] addr);
      return addr[31:2];
   endfunction

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Loader handshake plus the single-port memory bus owned by the arbiter.
interface instr_mem_arbiter_if #(parameter int IDX_W = 10);

   logic             ld_req;
   logic             ld_grant;
   logic             ld_valid;
   logic             ld_ready;
   logic             ld_we;
   logic [31:0]      ld_addr;
   logic [31:0]      ld_wdata;
   logic             ld_rvalid;
   logic [31:0]      ld_rdata;
   logic             ld_done;
   logic             ld_restart;
   logic             ld_error;
   logic [15:0]      ld_word_count;
   logic [IDX_W-1:0] mem_addr;
   logic             mem_we;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;

   // Loader and memory side.
   modport master (
      output ld_req, ld_valid, ld_we, ld_addr, ld_wdata, ld_done, ld_restart, mem_rdata,
      input  ld_grant, ld_ready, ld_rvalid, ld_rdata, ld_error, ld_word_count,
             mem_addr, mem_we, mem_wdata
   );

   // Arbiter side.
   modport slave (
      input  ld_req, ld_valid, ld_we, ld_addr, ld_wdata, ld_done, ld_restart, mem_rdata,
      output ld_grant, ld_ready, ld_rvalid, ld_rdata, ld_error, ld_word_count,
             mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/instr_mem_arbiter.sv
// Arbitrates the instruction memory port between fetch and an external loader,
// freezing the core for the session and refilling the fetch word on release.
module instr_mem_arbiter
   import instr_mem_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int IDX_W     = 10,
   parameter int TIMEOUT   = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         fetch_addr,
   output logic [31:0]         fetch_rd,
   output logic                core_hold,
   output logic                core_restart,
   instr_mem_arbiter_if.slave  bus
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   arb_state_t       state, state_nx;
   logic [IDX_W-1:0] fetch_idx, ld_idx, saved_idx;
   logic [TO_W-1:0]  idle_cnt;
   logic             refill_zero, rd_pend, rd_inv;
   logic             xfer, ld_ok, exit_load, timeout_hit;

   assign fetch_idx   = IDX_W'(word_index(fetch_addr));
   assign ld_idx      = IDX_W'(word_index(bus.ld_addr));
   assign ld_ok       = addr_valid(bus.ld_addr, MEM_WORDS);
   assign xfer        = (state == LOAD) && bus.ld_valid;
   // A transfer in the same cycle as done/drop always wins; exit is re-checked later.
   assign exit_load   = !bus.ld_valid && (bus.ld_done || !bus.ld_req);
   assign timeout_hit = (state == LOAD) && !xfer && (idle_cnt == TO_W'(TIMEOUT - 1));

   assign fetch_rd      = bus.mem_rdata;
   assign bus.mem_wdata = bus.ld_wdata;
   assign bus.ld_grant  = (state == LOAD);
   assign bus.ld_ready  = (state == LOAD);
   assign bus.ld_rvalid = rd_pend;
   assign bus.ld_rdata  = (rd_pend && !rd_inv) ? bus.mem_rdata : '0;
   assign core_restart  = (state == REFILL) && refill_zero;

   always_comb begin
      state_nx     = state;
      bus.mem_addr = fetch_idx;
      bus.mem_we   = 1'b0;
      case (state)
         RUN:  if (bus.ld_req) state_nx = HOLD;
         HOLD: state_nx = LOAD;
         LOAD: begin
            bus.mem_addr = ld_idx;
            bus.mem_we   = xfer && bus.ld_we && ld_ok;
            if (exit_load || timeout_hit) state_nx = REFILL;
         end
         REFILL: begin
            bus.mem_addr = refill_zero ? '0 : saved_idx;
            state_nx     = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= RUN;
         core_hold         <= 1'b0;
         saved_idx         <= '0;
         refill_zero       <= 1'b0;
         idle_cnt          <= '0;
         rd_pend           <= 1'b0;
         rd_inv            <= 1'b0;
         bus.ld_error      <= 1'b0;
         bus.ld_word_count <= '0;
      end else begin
         state     <= state_nx;
         core_hold <= (state_nx != RUN);
         rd_pend   <= xfer && !bus.ld_we;
         rd_inv    <= xfer && !ld_ok;
         case (state)
            HOLD: begin
               saved_idx         <= fetch_idx;
               idle_cnt          <= '0;
               bus.ld_error      <= 1'b0;
               bus.ld_word_count <= '0;
            end
            LOAD: begin
               if (xfer)              idle_cnt <= '0;
               else if (!timeout_hit) idle_cnt <= idle_cnt + TO_W'(1);
               if ((xfer && !ld_ok) || timeout_hit) bus.ld_error <= 1'b1;
               if (xfer && bus.ld_we && ld_ok && (bus.ld_word_count != 16'hFFFF))
                  bus.ld_word_count <= bus.ld_word_count + 16'd1;
               if (state_nx == REFILL)
                  refill_zero <= exit_load && bus.ld_done && bus.ld_restart;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter with a per-cycle reference model.
module tb_instr_mem_arbiter;

   localparam int MEM_WORDS = 1024;
   localparam int IDX_W     = 10;
   localparam int TIMEOUT   = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetch_addr, fetch_rd;
   logic        core_hold, core_restart;
   int          n_tests = 0;
   int          n_fail  = 0;

   logic [31:0] sram    [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   logic        sram_init = 1'b0;
   logic        ref_init  = 1'b0;

   instr_mem_arbiter_if #(.IDX_W(IDX_W)) bus ();

   instr_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_rd(fetch_rd),
      .core_hold(core_hold), .core_restart(core_restart), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return 32'hA000_0000 | 32'(i);
   endfunction

   function automatic logic addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'(4 * MEM_WORDS));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous-read single-port memory.
   always @(posedge clk) begin
      if (!sram_init) begin
         for (int i = 0; i < MEM_WORDS; i++) sram[i] <= pat(i);
         sram_init <= 1'b1;
      end else begin
         if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= sram[bus.mem_addr];
      end
   end

   // Reference model: intended memory image, session counters and exit bookkeeping.
   logic             p_ok, p_grant, p_hold, p_rd, m_rz, m_err;
   logic [31:0]      p_rval;
   logic [IDX_W-1:0] p_fidx, m_saved;
   logic [15:0]      m_cnt;
   int               m_idle;

   always @(negedge clk) begin
      logic             g, ok, wr;
      logic [IDX_W-1:0] idx;
      if (!ref_init) begin
         for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);
         ref_init = 1'b1;
      end
      if (!reset) begin
         p_ok = 1'b0; p_grant = 1'b0; p_hold = 1'b0; p_rd = 1'b0; m_rz = 1'b0;
         m_err = 1'b0; m_cnt = '0; m_idle = 0; p_rval = '0; p_fidx = '0; m_saved = '0;
      end else begin
         g   = bus.ld_grant;
         ok  = addr_ok(bus.ld_addr);
         idx = bus.ld_addr[IDX_W+1:2];
         if (g && !p_grant) begin m_cnt = '0; m_err = 1'b0; m_idle = 0; end
         if (core_hold && !p_hold) m_saved = fetch_addr[IDX_W+1:2];

         wr = g && bus.ld_valid && bus.ld_we && ok;
         check("mem_we", 32'(bus.mem_we), 32'(wr));
         if (wr) begin
            check("wr_addr", 32'(bus.mem_addr), 32'(idx));
            check("wr_data", bus.mem_wdata, bus.ld_wdata);
         end
         if (!core_hold) check("run_addr", 32'(bus.mem_addr), 32'(fetch_addr[IDX_W+1:2]));
         check("rvalid", 32'(bus.ld_rvalid), 32'(p_rd));
         if (p_rd) check("rdata", bus.ld_rdata, p_rval);
         check("word_count", 32'(bus.ld_word_count), 32'(m_cnt));
         check("error", 32'(bus.ld_error), 32'(m_err));
         check("restart", 32'(core_restart), 32'(p_grant && !g && m_rz));
         if (!core_hold && p_ok && !p_hold) check("fetch_rd", fetch_rd, ref_mem[p_fidx]);
         if (!core_hold && p_hold) check("refill_rd", fetch_rd, ref_mem[m_rz ? '0 : m_saved]);

         p_rd   = g && bus.ld_valid && !bus.ld_we;
         p_rval = ok ? ref_mem[idx] : 32'h0;
         if (g && bus.ld_valid) begin
            m_idle = 0;
            if (!ok) m_err = 1'b1;
            else if (bus.ld_we) begin
               ref_mem[idx] = bus.ld_wdata;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end else if (g) begin
            m_idle++;
            if (m_idle == TIMEOUT) m_err = 1'b1;
         end
         if (g && !bus.ld_valid && (bus.ld_done || !bus.ld_req))
            m_rz = bus.ld_done && bus.ld_restart;
         else if (g && m_idle == TIMEOUT)
            m_rz = 1'b0;

         p_fidx  = fetch_addr[IDX_W+1:2];
         p_ok    = 1'b1;
         p_hold  = core_hold;
         p_grant = g;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic session_start();
      int n = 0;
      bus.ld_req = 1'b1;
      while (bus.ld_grant !== 1'b1 && n < 8) begin tick(); n++; end
      check("grant_wait", 32'(bus.ld_grant), 32'd1);
   endtask

   task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data);
      bus.ld_valid = 1'b1; bus.ld_we = we; bus.ld_addr = addr; bus.ld_wdata = data;
      tick();
      bus.ld_valid = 1'b0;
   endtask

   task automatic end_session(input logic rs);
      bus.ld_valid = 1'b0; bus.ld_done = 1'b1; bus.ld_restart = rs;
      tick();
      bus.ld_done = 1'b0; bus.ld_restart = 1'b0; bus.ld_req = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b0; fetch_addr = '0;
      bus.ld_req = 1'b0; bus.ld_valid = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0;
      bus.ld_wdata = '0; bus.ld_done = 1'b0; bus.ld_restart = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hold", 32'(core_hold), 32'd0);
      check("rst_grant", 32'(bus.ld_grant), 32'd0);
      check("rst_ready", 32'(bus.ld_ready), 32'd0);
      check("rst_rvalid", 32'(bus.ld_rvalid), 32'd0);
      check("rst_rdata", bus.ld_rdata, 32'd0);
      check("rst_error", 32'(bus.ld_error), 32'd0);
      check("rst_count", 32'(bus.ld_word_count), 32'd0);
      check("rst_restart", 32'(core_restart), 32'd0);
      tick(); reset = 1'b1;

      // Fetch only
      @(negedge clk); check("f_addr0", 32'(bus.mem_addr), 32'd0);
      tick(); fetch_addr = 32'h4;
      @(negedge clk); check("f_addr1", 32'(bus.mem_addr), 32'd1);
      check("f_rd0", fetch_rd, 32'hA000_0000);
      tick(); fetch_addr = 32'h8;
      @(negedge clk); check("f_addr2", 32'(bus.mem_addr), 32'd2);
      check("f_rd1", fetch_rd, 32'hA000_0001);
      tick(); fetch_addr = 32'h10;
      @(negedge clk); check("f_rd2", fetch_rd, 32'hA000_0002);
      check("f_hold", 32'(core_hold), 32'd0);

      // Load session with two writes
      tick(); bus.ld_req = 1'b1;
      tick();
      @(negedge clk); check("hold_on", 32'(core_hold), 32'd1);
      check("hold_grant", 32'(bus.ld_grant), 32'd0);
      check("hold_addr", 32'(bus.mem_addr), 32'd4);
      tick();
      @(negedge clk); check("load_grant", 32'(bus.ld_grant), 32'd1);
      tick();
      bus.ld_valid = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h0; bus.ld_wdata = 32'hDEADBEEF;
      @(negedge clk); check("w0_we", 32'(bus.mem_we), 32'd1);
      check("w0_addr", 32'(bus.mem_addr), 32'd0);
      tick(); bus.ld_addr = 32'h4; bus.ld_wdata = 32'h12345678;
      @(negedge clk); check("w1_addr", 32'(bus.mem_addr), 32'd1);
      check("w1_data", bus.mem_wdata, 32'h12345678);
      tick(); bus.ld_valid = 1'b0; bus.ld_done = 1'b1;
      @(negedge clk); check("w_count", 32'(bus.ld_word_count), 32'd2);
      tick(); bus.ld_done = 1'b0; bus.ld_req = 1'b0;
      @(negedge clk); check("refill_addr", 32'(bus.mem_addr), 32'd4);
      check("refill_grant", 32'(bus.ld_grant), 32'd0);
      check("refill_hold", 32'(core_hold), 32'd1);
      tick();
      @(negedge clk); check("release_hold", 32'(core_hold), 32'd0);
      check("release_rd", fetch_rd, 32'hA000_0004);

      // Readback
      tick(); session_start();
      do_xfer(1'b1, 32'h8, 32'hCAFEF00D);
      bus.ld_valid = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h8;
      tick(); bus.ld_valid = 1'b0;
      @(negedge clk); check("rb_rvalid", 32'(bus.ld_rvalid), 32'd1);
      check("rb_rdata", bus.ld_rdata, 32'hCAFEF00D);
      tick();
      @(negedge clk); check("rb_pulse", 32'(bus.ld_rvalid), 32'd0);
      tick(); end_session(1'b0); tick();

      // Errors
      session_start();
      bus.ld_valid = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h6; bus.ld_wdata = 32'h1111_1111;
      @(negedge clk); check("err_unal_we", 32'(bus.mem_we), 32'd0);
      tick(); bus.ld_addr = 32'(4 * MEM_WORDS);
      @(negedge clk); check("err_range_we", 32'(bus.mem_we), 32'd0);
      tick(); bus.ld_valid = 1'b0;
      @(negedge clk); check("err_flag", 32'(bus.ld_error), 32'd1);
      check("err_count", 32'(bus.ld_word_count), 32'd0);
      end_session(1'b0);
      @(negedge clk); check("err_sticky_refill", 32'(bus.ld_error), 32'd1);
      tick();
      @(negedge clk); check("err_sticky_run", 32'(bus.ld_error), 32'd1);

      // Restart
      tick(); session_start();
      @(negedge clk); check("err_cleared", 32'(bus.ld_error), 32'd0);
      tick(); end_session(1'b1);
      @(negedge clk); check("rs_pulse", 32'(core_restart), 32'd1);
      check("rs_addr", 32'(bus.mem_addr), 32'd0);
      tick();
      @(negedge clk); check("rs_single", 32'(core_restart), 32'd0);
      check("rs_rd", fetch_rd, 32'hDEADBEEF);

      // Timeout, then ld_req held across REFILL
      tick(); session_start();
      n = 0;
      while (bus.ld_grant === 1'b1 && n < TIMEOUT + 16) begin tick(); n++; end
      check("to_len", 32'(n), 32'(TIMEOUT));
      @(negedge clk); check("to_error", 32'(bus.ld_error), 32'd1);
      tick();
      @(negedge clk); check("gap_run", 32'(core_hold), 32'd0);
      tick();
      @(negedge clk); check("gap_rehold", 32'(core_hold), 32'd1);
      bus.ld_req = 1'b0;
      tick();
      @(negedge clk); check("drop_grant", 32'(bus.ld_grant), 32'd1);
      tick(); tick();
      @(negedge clk); check("drop_run", 32'(core_hold), 32'd0);

      // Reset mid-LOAD with a write pending
      tick(); session_start();
      bus.ld_valid = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'h5555_5555;
      #2 reset = 1'b0;
      #1;
      check("mr_we", 32'(bus.mem_we), 32'd0);
      check("mr_hold", 32'(core_hold), 32'd0);
      check("mr_grant", 32'(bus.ld_grant), 32'd0);
      check("mr_ready", 32'(bus.ld_ready), 32'd0);
      check("mr_count", 32'(bus.ld_word_count), 32'd0);
      check("mr_error", 32'(bus.ld_error), 32'd0);
      check("mr_rvalid", 32'(bus.ld_rvalid), 32'd0);
      tick(); reset = 1'b1; bus.ld_valid = 1'b0; bus.ld_req = 1'b0;
      @(negedge clk); check("mr_mem", sram[8], 32'hA000_0008);
      tick();
      @(negedge clk); check("mr_run", 32'(core_hold), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
